// File: rtl/board_move_scheduler_pkg.sv
// Shared definitions for the move-generation scheduler: default geometry and FSM states.
package board_move_scheduler_pkg;

    localparam int unsigned NCOL_DEF   = 8;
    localparam int unsigned WORD_W_DEF = 152;
    localparam int unsigned COL_W      = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WAIT,
        SEL,
        RD,
        CAP,
        OUT,
        FIN
    } state_t;

endpackage

// File: rtl/board_move_scheduler_rr_select.sv
// Round-robin picker: first requesting index after ptr, wrapping modulo N.
module rr_select
    import board_move_scheduler_pkg::*;
#(
    parameter int unsigned N  = NCOL_DEF,
    parameter int unsigned IW = COL_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_grant
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!any_grant && req[IW'(idx)]) begin
                grant     = IW'(idx);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_move_scheduler.sv
// Restarts the column units, waits for all to finish, then drains their FIFOs
// round-robin one word at a time onto a valid/ready output.
module board_move_scheduler
    import board_move_scheduler_pkg::*;
#(
    parameter int unsigned NCOL    = NCOL_DEF,
    parameter int unsigned WORD_W  = WORD_W_DEF,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     col_reset,
    input  logic [NCOL-1:0]          col_done,
    input  logic [NCOL-1:0]          col_empty,
    input  logic [NCOL*WORD_W-1:0]   col_data,
    output logic [NCOL-1:0]          col_rden,
    output logic                     m_valid,
    output logic [WORD_W-1:0]        m_data,
    output logic [COL_W-1:0]         m_col,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     gen_done,
    output logic                     timeout_err,
    output logic [CNT_W-1:0]         move_count
);

    localparam int unsigned WT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [COL_W-1:0]  ptr;
    logic [COL_W-1:0]  grant;
    logic              any_grant;
    logic [NCOL-1:0]   req;
    logic              clr_second;
    logic [WT_W-1:0]   wcnt;

    assign req = ~col_empty;

    rr_select #(
        .N  (NCOL),
        .IW (COL_W)
    ) u_rr_select (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CLR;
            CLR:  if (clr_second) state_nxt = WAIT;
            WAIT: begin
                if (&col_done)           state_nxt = SEL;
                else if (wcnt == WT_LAST) state_nxt = FIN;
            end
            SEL:  state_nxt = any_grant ? RD : FIN;
            RD:   state_nxt = CAP;
            CAP:  state_nxt = OUT;
            OUT:  if (m_ready) state_nxt = SEL;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= COL_W'(NCOL - 1);
            clr_second  <= 1'b0;
            wcnt        <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_col       <= '0;
            timeout_err <= 1'b0;
            move_count  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ptr         <= COL_W'(NCOL - 1);
                    clr_second  <= 1'b0;
                    wcnt        <= '0;
                    timeout_err <= 1'b0;
                    move_count  <= '0;
                end
                CLR: begin
                    clr_second <= ~clr_second;
                    wcnt       <= '0;
                end
                WAIT: begin
                    if (!(&col_done) && wcnt == WT_LAST) timeout_err <= 1'b1;
                    wcnt <= wcnt + 1'b1;
                end
                SEL: if (any_grant) ptr <= grant;
                // FIFO output is valid one cycle after its read enable
                CAP: begin
                    m_data  <= col_data[ptr*WORD_W +: WORD_W];
                    m_col   <= ptr;
                    m_valid <= 1'b1;
                end
                OUT: if (m_ready) begin
                    m_valid <= 1'b0;
                    if (move_count != '1) move_count <= move_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Combinational outputs are masked by reset so nothing escapes on the reset cycle
    always_comb begin
        col_rden = '0;
        if (state == RD && !reset) col_rden[ptr] = 1'b1;
    end

    assign col_reset = reset | (state == CLR);
    assign busy      = !reset && (state != IDLE);
    assign gen_done  = !reset && (state == FIN);

endmodule

// File: tb/tb_board_move_scheduler.sv
// Self-checking bench: FIFO/column-unit models, table scenarios, corner sequences, random runs.
module tb_board_move_scheduler;
    import board_move_scheduler_pkg::*;

    localparam int NC  = 8;
    localparam int W   = 152;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset, start, m_ready;
    logic [NC-1:0]   col_done, col_empty, col_rden, col_rden_b;
    logic [NC*W-1:0] col_data;
    logic            col_reset, m_valid, busy, gen_done, timeout_err;
    logic [W-1:0]    m_data;
    logic [2:0]      m_col;
    logic [9:0]      move_count;
    logic            col_reset_b, m_valid_b, busy_b, gen_done_b, timeout_err_b;
    logic [W-1:0]    m_data_b;
    logic [2:0]      m_col_b;
    logic [1:0]      move_count_b;

    always #5 clk = ~clk;

    board_move_scheduler #(.NCOL(NC), .WORD_W(W), .CNT_W(10), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .col_reset(col_reset),
        .col_done(col_done), .col_empty(col_empty), .col_data(col_data), .col_rden(col_rden),
        .m_valid(m_valid), .m_data(m_data), .m_col(m_col), .m_ready(m_ready),
        .busy(busy), .gen_done(gen_done), .timeout_err(timeout_err), .move_count(move_count)
    );

    // Lockstep copy with a 2-bit counter; sees identical inputs, only its count is checked
    board_move_scheduler #(.NCOL(NC), .WORD_W(W), .CNT_W(2), .TIMEOUT(TMO)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .col_reset(col_reset_b),
        .col_done(col_done), .col_empty(col_empty), .col_data(col_data), .col_rden(col_rden_b),
        .m_valid(m_valid_b), .m_data(m_data_b), .m_col(m_col_b), .m_ready(m_ready),
        .busy(busy_b), .gen_done(gen_done_b), .timeout_err(timeout_err_b), .move_count(move_count_b)
    );

    // Column FIFO model, 1-cycle read latency
    logic [W-1:0] mem [NC][64];
    int unsigned  wr [NC];
    int unsigned  rd [NC];
    logic [W-1:0] dout [NC] = '{default: '0};

    always_comb begin
        for (int i = 0; i < NC; i++) begin
            col_empty[i]         = (wr[i] == rd[i]);
            col_data[i*W +: W]   = dout[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (col_rden[i] && wr[i] != rd[i]) begin
                dout[i] <= mem[i][rd[i] % 64];
                rd[i]   <= rd[i] + 1;
            end
        end
    end

    // Column units report done a fixed delay after their restart
    int unsigned     done_delay;
    logic [NC-1:0]   done_mask;
    int unsigned     done_timer = 0;
    always @(posedge clk) begin
        if (col_reset)              done_timer <= 0;
        else if (done_timer < 1000) done_timer <= done_timer + 1;
    end
    assign col_done = (done_timer >= done_delay) ? done_mask : '0;

    int gd_cnt = 0, cr_cnt = 0, rden_pulses = 0, rden_bad = 0;
    always @(negedge clk) begin
        if (gen_done)  gd_cnt <= gd_cnt + 1;
        if (col_reset) cr_cnt <= cr_cnt + 1;
        if (col_rden != '0) begin
            rden_pulses <= rden_pulses + 1;
            if (!$onehot(col_rden) || (col_rden & col_empty) != '0) rden_bad <= rden_bad + 1;
        end
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    task automatic push(input int c, input logic [W-1:0] d);
        mem[c][wr[c] % 64] = d;
        wr[c] = wr[c] + 1;
    endtask

    typedef struct { int col; logic [W-1:0] data; } exp_t;
    exp_t expq[$];

    // Expected delivery: repeatedly take the next non-empty column after the last one served
    task automatic build_exp();
        int left[NC];
        int base[NC];
        int p;
        bit found;
        expq.delete();
        for (int i = 0; i < NC; i++) begin
            left[i] = int'(wr[i] - rd[i]);
            base[i] = int'(rd[i]);
        end
        p = NC - 1;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= NC && !found; k++) begin
                int c;
                c = (p + k) % NC;
                if (left[c] > 0) begin
                    expq.push_back('{c, mem[c][base[c] % 64]});
                    base[c]++;
                    left[c]--;
                    p = c;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic run_gen(input string tag, input int unsigned ready_pct, input int exp_cnt);
        int gd0, rp0, rb0, cr0, n_exp, got, cyc, order_bad, stab_bad, sat;
        bit done, pend;
        logic [W-1:0] last_d;
        gd0 = gd_cnt; rp0 = rden_pulses; rb0 = rden_bad; cr0 = cr_cnt;
        build_exp();
        n_exp = expq.size();
        got = 0; cyc = 0; order_bad = 0; stab_bad = 0; done = 1'b0; pend = 1'b0; last_d = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && cyc < 3000) begin
            m_ready = ($urandom_range(99) < ready_pct);
            start   = busy && ($urandom_range(3) == 0);
            if (pend && (!m_valid || m_data !== last_d)) stab_bad++;
            if (m_valid && m_ready) begin
                if (expq.size() == 0 || m_col != 3'(expq[0].col) || m_data !== expq[0].data)
                    order_bad++;
                if (expq.size() > 0) void'(expq.pop_front());
                got++;
                pend = 1'b0;
            end else begin
                pend   = m_valid;
                last_d = m_data;
            end
            if (gen_done) done = 1'b1;
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        start   = 1'b0;
        sat = (exp_cnt > 3) ? 3 : exp_cnt;
        check({tag, ".finished"},  W'(done), W'(1));
        check({tag, ".model_cnt"}, W'(n_exp), W'(exp_cnt));
        check({tag, ".order"},     W'(order_bad), W'(0));
        check({tag, ".stable"},    W'(stab_bad), W'(0));
        check({tag, ".delivered"}, W'(got), W'(exp_cnt));
        check({tag, ".count"},     W'(move_count), W'(exp_cnt));
        check({tag, ".count_sat"}, W'(move_count_b), W'(sat));
        check({tag, ".rden"},      W'(rden_pulses - rp0), W'(exp_cnt));
        check({tag, ".rden_ok"},   W'(rden_bad - rb0), W'(0));
        check({tag, ".gen_done"},  W'(gd_cnt - gd0), W'(1));
        check({tag, ".col_reset"}, W'(cr_cnt - cr0), W'(2));
        check({tag, ".idle"},      W'(busy), W'(0));
    endtask

    typedef struct {
        logic [31:0] fill;
        int unsigned delay;
        int unsigned ready_pct;
        int          exp_cnt;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int cyc, wcyc, rp0, gd0, cr0, stab_bad;
        logic [W-1:0] d0;
        logic [W-1:0] w7;

        tbl[0] = '{32'h0000_0000, 5, 100, 0};
        tbl[1] = '{32'h0020_0200, 0, 100, 4};
        tbl[2] = '{32'h1111_1111, 12, 50, 8};
        tbl[3] = '{32'h0000_1003, 3, 30, 4};

        reset = 1'b1; start = 1'b0; m_ready = 1'b0;
        done_mask = '1; done_delay = 5;
        repeat (3) tick();
        check("rst.m_valid",     W'(m_valid), W'(0));
        check("rst.m_data",      m_data, '0);
        check("rst.m_col",       W'(m_col), W'(0));
        check("rst.col_rden",    W'(col_rden), W'(0));
        check("rst.gen_done",    W'(gen_done), W'(0));
        check("rst.timeout_err", W'(timeout_err), W'(0));
        check("rst.move_count",  W'(move_count), W'(0));
        check("rst.busy",        W'(busy), W'(0));
        check("rst.col_reset",   W'(col_reset), W'(1));
        reset = 1'b0;
        tick();

        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < NC; c++) begin
                logic [31:0] f;
                f = tbl[v].fill;
                for (int k = 0; k < int'(f[c*4 +: 4]); k++) push(c, rand_word());
            end
            done_delay = tbl[v].delay;
            run_gen($sformatf("tbl%0d", v), tbl[v].ready_pct, tbl[v].exp_cnt);
            tick();
        end

        // Single word held back by the consumer
        w7 = rand_word();
        push(7, w7);
        rp0 = rden_pulses; done_delay = 2; stab_bad = 0;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 200) begin tick(); cyc++; end
        check("hold.valid", W'(m_valid), W'(1));
        d0 = m_data;
        check("hold.data", d0, w7);
        check("hold.col", W'(m_col), W'(7));
        for (int k = 0; k < 10; k++) begin
            if (!m_valid || m_data !== d0) stab_bad++;
            tick();
        end
        check("hold.stable", W'(stab_bad), W'(0));
        check("hold.count_before", W'(move_count), W'(0));
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        check("hold.dropped", W'(m_valid), W'(0));
        cyc = 0;
        while (!gen_done && cyc < 200) begin tick(); cyc++; end
        check("hold.gen_done", W'(gen_done), W'(1));
        check("hold.count", W'(move_count), W'(1));
        check("hold.rden", W'(rden_pulses - rp0), W'(1));
        tick();

        // Timeout with one column never finishing
        done_mask = 8'hFE; done_delay = 0; rp0 = rden_pulses;
        push(3, rand_word());
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0; wcyc = 0;
        while (!gen_done && cyc < 200) begin
            if (busy && !col_reset) wcyc++;
            tick(); cyc++;
        end
        check("tmo.wait_cycles", W'(wcyc), W'(TMO));
        check("tmo.err_fin", W'(timeout_err), W'(1));
        check("tmo.rden", W'(rden_pulses - rp0), W'(0));
        tick();
        check("tmo.err_sticky", W'(timeout_err), W'(1));
        check("tmo.idle", W'(busy), W'(0));
        done_mask = '1;
        run_gen("tmo_clear", 100, 1);
        check("tmo.err_cleared", W'(timeout_err), W'(0));
        tick();

        // Reset while a word is waiting in OUT; restarts during busy must be ignored
        push(1, rand_word());
        push(1, rand_word());
        done_delay = 3; gd0 = gd_cnt; cr0 = cr_cnt;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 200) begin
            start = busy;
            tick(); cyc++;
        end
        start = 1'b0;
        repeat (2) begin start = 1'b1; tick(); end
        start = 1'b0;
        check("rst_out.valid", W'(m_valid), W'(1));
        check("rst_out.clr_once", W'(cr_cnt - cr0), W'(2));
        reset = 1'b1;
        #1;
        check("rst_out.rden", W'(col_rden), W'(0));
        check("rst_out.busy_in", W'(busy), W'(0));
        check("rst_out.col_reset", W'(col_reset), W'(1));
        tick();
        reset = 1'b0;
        check("rst_out.valid_after", W'(m_valid), W'(0));
        check("rst_out.busy_after", W'(busy), W'(0));
        check("rst_out.count", W'(move_count), W'(0));
        tick();
        check("rst_out.still_idle", W'(busy), W'(0));
        check("rst_out.no_done", W'(gd_cnt - gd0), W'(0));
        run_gen("rst_out.rest", 70, 1);
        tick();

        for (int r = 0; r < 8; r++) begin
            int n;
            n = 0;
            for (int c = 0; c < NC; c++) begin
                int k;
                k = int'($urandom_range(3));
                n += k;
                for (int j = 0; j < k; j++) push(c, rand_word());
            end
            done_delay = $urandom_range(10);
            run_gen($sformatf("rnd%0d", r), $urandom_range(100, 20), n);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/board_move_scheduler.md
BOARD_MOVE_SCHEDULER -- requirements
Module: board_move_scheduler

Interface
REQ-001 SHALL have parameter NCOL, default 8: number of column units served.
REQ-002 SHALL have parameter WORD_W, default 152: column FIFO word width (8 x 19-bit move records, passed through opaque).
REQ-003 SHALL have parameter CNT_W, default 10: width of the delivered-word counter.
REQ-004 SHALL have parameter TIMEOUT, default 4096: maximum number of WAIT cycles before abort.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: single-cycle request to generate and collect moves.
REQ-008 SHALL have port col_reset, output, 1: restart pulse to all column units.
REQ-009 SHALL have port col_done, input, NCOL: per-column done flag.
REQ-010 SHALL have port col_empty, input, NCOL: per-column FIFO empty flag.
REQ-011 SHALL have port col_data, input, NCOL*WORD_W: concatenated column FIFO outputs, column i at [i*WORD_W +: WORD_W].
REQ-012 SHALL have port col_rden, output, NCOL: one-hot column FIFO read enable.
REQ-013 SHALL have port m_valid, output, 1: m_data holds a word.
REQ-014 SHALL have port m_data, output, WORD_W: collected word.
REQ-015 SHALL have port m_col, output, 3: source column index of m_data.
REQ-016 SHALL have port m_ready, input, 1: consumer accepts the word.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-018 SHALL have port gen_done, output, 1: one-cycle completion pulse.
REQ-019 SHALL have port timeout_err, output, 1: sticky abort flag, cleared by the next accepted start or by reset.
REQ-020 SHALL have port move_count, output, CNT_W: number of words accepted since the last start, saturating.

Function
REQ-021 SHALL implement the states IDLE, CLR, WAIT, SEL, RD, CAP, OUT and FIN.
REQ-022 IDLE: start=1 SHALL cause a transition to CLR and clear move_count, timeout_err and the round-robin pointer (ptr=NCOL-1).
REQ-023 start SHALL be ignored in every state other than IDLE.
REQ-024 col_reset SHALL equal reset OR (state==CLR); CLR SHALL last exactly 2 cycles and then go to WAIT.
REQ-025 WAIT: when &col_done is 1, the block SHALL go to SEL.
REQ-026 WAIT: when the wait counter reaches TIMEOUT-1 without &col_done, the block SHALL set timeout_err and go to FIN without reading any column.
REQ-027 SEL: the block SHALL pick the first column c with col_empty[c]=0, searching from ptr+1 modulo NCOL (wrap-around), then set ptr=c and go to RD.
REQ-028 SEL: if every column is empty, the block SHALL go to FIN.
REQ-029 RD: col_rden SHALL be one-hot at bit ptr for exactly 1 cycle; at all other times col_rden SHALL be 0.
REQ-030 CAP (the cycle after RD, 1-cycle FIFO read latency): the block SHALL register m_data=col_data[ptr], set m_col=ptr and m_valid=1, then go to OUT.
REQ-031 OUT: m_valid and m_data SHALL stay stable until a cycle with m_ready=1; on that cycle move_count SHALL increment (saturating at all-ones), m_valid SHALL drop next cycle, and the state SHALL return to SEL.
REQ-032 At most one FIFO read SHALL be outstanding, so no word is ever lost or duplicated.
REQ-033 FIN: gen_done SHALL be 1 for exactly 1 cycle, then the state SHALL return to IDLE.
REQ-034 m_ready asserted while m_valid=0 SHALL have no effect.

Reset
REQ-035 When reset=1, the state SHALL go to IDLE and outputs SHALL be: m_valid=0, m_data=0, m_col=0, col_rden=0, gen_done=0, timeout_err=0, move_count=0, busy=0, col_reset=1.
REQ-036 Reset asserted mid-operation, including in OUT with an unaccepted word, SHALL discard that word; no col_rden SHALL be issued on the reset cycle.

Structure
REQ-037 The state encoding, NCOL, WORD_W and the column-index width SHALL live in the shared chess package.
REQ-038 The round-robin search from REQ-027 SHALL be a sub-module rr_select (inputs: request vector and pointer; outputs: grant index and any-grant flag).

Verification
REQ-039 Reset, start, all col_done=1 after 5 cycles, all empty -> col_reset high 2 cycles, gen_done pulse, move_count=0, no col_rden.
REQ-040 Columns 2 and 5 hold 2 words each, m_ready=1 -> m_col order 2,5,2,5; move_count=4; gen_done once.
REQ-041 One word in column 7, m_ready held low 10 cycles -> m_data stable the whole time, exactly one col_rden pulse, count=1 after release.
REQ-042 TIMEOUT=16, col_done stuck at 0xFE -> timeout_err=1 and gen_done pulse at cycle 16 of WAIT; next start clears timeout_err.
REQ-043 Reset asserted in OUT -> m_valid=0 next cycle, state IDLE, busy=0; start pulses during busy ignored.
REQ-044 CNT_W=2, 5 words delivered -> move_count saturates at 3.
